// File: rtl/countdown_timer.sv
// +--------------------------------------------------------------------------+
// | Module      : countdown_timer                                            |
// | Description : Game-length countdown. A prescaler divides clk into ticks  |
// |               of TICK_CYCLES cycles, and each tick takes one second off  |
// |               the remaining time, from GAME_SECONDS down to 0.           |
// |               game_over is registered and stays high at 0 until a        |
// |               restart. Optional macro COUNTDOWN_PAUSE_EN adds a pause    |
// |               input that freezes both the prescaler and the count.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module countdown_timer #(
  parameter int TICK_CYCLES  = 100_000_000,
  parameter int GAME_SECONDS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart_game,
`ifdef COUNTDOWN_PAUSE_EN
  input  logic       pause,
`endif
  output logic [4:0] seconds,
  output logic       game_over
);

  // The prescaler is wide enough to hold TICK_CYCLES-1. TICK_CYCLES is at least 2.
  localparam int         c_PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [c_PW-1:0] c_TICK_LAST = c_PW'(TICK_CYCLES - 1);
  localparam logic [4:0] c_START     = 5'(GAME_SECONDS);

  logic [c_PW-1:0] r_presc;
  logic [4:0]      r_seconds;
  logic            r_game_over;
  logic            w_run;
  logic            w_tick;

  // The timer advances unless it is paused. Without the pause option it always runs.
`ifdef COUNTDOWN_PAUSE_EN
  assign w_run = ~pause;
`else
  assign w_run = 1'b1;
`endif

  // A tick occurs in the last prescaler cycle, and only while the timer is running.
  assign w_tick = w_run && (r_presc == c_TICK_LAST);

  // Prescaler, seconds and the expiry flag. Restart takes priority over a tick.
  // When seconds reaches 0 the count stays there, and game_over is set on the
  // same edge that stores the 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_seconds   <= c_START;
      r_game_over <= 1'b0;
    end else if (restart_game) begin
      r_presc     <= '0;
      r_seconds   <= c_START;
      r_game_over <= 1'b0;
    end else if (w_run) begin
      if (w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + c_PW'(1);
      end
      if (w_tick && (r_seconds != 5'd0)) begin
        r_seconds <= r_seconds - 5'd1;
        if (r_seconds == 5'd1) begin
          r_game_over <= 1'b1;
        end
      end
    end
  end

  assign seconds   = r_seconds;
  assign game_over = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_countdown_timer                                         |
// | Description : Directed self-checking bench for countdown_timer, with     |
// |               TICK_CYCLES=10 and GAME_SECONDS=30. Define                 |
// |               COUNTDOWN_PAUSE_EN to include the pause checks.            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       restart_game;
  logic       pause;
  logic [4:0] seconds;
  logic       game_over;

  int r_checks;
  int r_failures;

  countdown_timer #(
    .TICK_CYCLES (10),
    .GAME_SECONDS(30)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart_game(restart_game),
`ifdef COUNTDOWN_PAUSE_EN
    .pause       (pause),
`endif
    .seconds     (seconds),
    .game_over   (game_over)
  );

  // Clock with a 10 time-unit period. Rising edges are at 5, 15, 25 and so on.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison. Report it when the value is not the expected one.
  task automatic check_value(input string tag, input int actual, input int expected);
    r_checks++;
    if (actual !== expected) begin
      r_failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Let n rising edges pass, then stop at the next falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    r_checks     = 0;
    r_failures   = 0;
    rst_n        = 1'b0;
    restart_game = 1'b0;
    pause        = 1'b0;

    // Values held while in reset
    step(2);
    check_value("reset_seconds", int'(seconds), 30);
    check_value("reset_game_over", int'(game_over), 0);

    // Release reset at a falling edge. The first decrement comes on edge 10.
    rst_n = 1'b1;
    step(9);
    check_value("edge9_seconds", int'(seconds), 30);
    step(1);
    check_value("edge10_seconds", int'(seconds), 29);
    step(10);
    check_value("edge20_seconds", int'(seconds), 28);

    // Run to expiry: at edge 299 the count is 1, and at edge 300 it is 0 with game_over set
    step(279);
    check_value("edge299_seconds", int'(seconds), 1);
    check_value("edge299_game_over", int'(game_over), 0);
    step(1);
    check_value("edge300_seconds", int'(seconds), 0);
    check_value("edge300_game_over", int'(game_over), 1);
    step(100);
    check_value("hold_seconds", int'(seconds), 0);
    check_value("hold_game_over", int'(game_over), 1);

    // One-cycle restart after expiry
    restart_game = 1'b1;
    step(1);
    restart_game = 1'b0;
    check_value("restart_seconds", int'(seconds), 30);
    check_value("restart_game_over", int'(game_over), 0);
    step(9);
    check_value("restart_e9_seconds", int'(seconds), 30);
    step(1);
    check_value("restart_e10_seconds", int'(seconds), 29);

    // At edge 190 the count would go from 12 to 11. A restart on that edge must win.
    step(170);
    check_value("pre_tick_seconds", int'(seconds), 12);
    step(9);
    restart_game = 1'b1;
    step(1);
    check_value("restart_on_tick", int'(seconds), 30);
    restart_game = 1'b0;
    step(10);
    check_value("after_tick_restart", int'(seconds), 29);

    // Drop reset between clock edges while the count is 7. It must take effect at once.
    step(220);
    check_value("pre_async_seconds", int'(seconds), 7);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("async_rst_seconds", int'(seconds), 30);
    check_value("async_rst_game_over", int'(game_over), 0);
    step(2);
    rst_n = 1'b1;
    step(10);
    check_value("post_async_seconds", int'(seconds), 29);

`ifdef COUNTDOWN_PAUSE_EN
    // At edge 100 the count is 20. Pause after 3 more edges (prescaler = 3).
    step(93);
    check_value("pre_pause_seconds", int'(seconds), 20);
    pause = 1'b1;
    step(50);
    check_value("paused_seconds", int'(seconds), 20);
    pause = 1'b0;
    step(6);
    check_value("resume_e6_seconds", int'(seconds), 20);
    step(1);
    check_value("resume_e7_seconds", int'(seconds), 19);

    // A restart still reloads while paused, and the count stays frozen afterwards
    pause        = 1'b1;
    restart_game = 1'b1;
    step(1);
    restart_game = 1'b0;
    step(20);
    check_value("paused_restart", int'(seconds), 30);
    pause = 1'b0;
    step(10);
    check_value("unpause_restart", int'(seconds), 29);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
    $finish;
  end

endmodule

`default_nettype wire
